// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
package fifo_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 10;
   localparam int unsigned DEFAULT_DEPTH      = 16;

   // Pointers carry one extra wrap bit above the storage address.
   function automatic int unsigned ptr_width(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one registered read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_data_d;

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   // Storage is deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO: wrap-bit pointers, accept logic and flag decode around fifo_mem.
module synchronous_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  w_enable,
   input  logic                  read_enable,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] wptr_d;
   logic [PTR_W-1:0] rptr_q;
   logic [PTR_W-1:0] rptr_d;
   logic             wr_accept;
   logic             rd_accept;

   // Flags depend only on registered pointers, never on this cycle's requests.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                  (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

   assign wr_accept = w_enable && !full;
   assign rd_accept = read_enable && !empty;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_accept) begin
         wptr_d = wptr_q + PTR_W'(1);
      end
      if (rd_accept) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (reset),
      .wr_en   (wr_accept),
      .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
      .wr_data (wr_data),
      .rd_en   (rd_accept),
      .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
      .rd_data (r_data)
   );

endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed self-checking bench for synchronous_fifo (16 x 10-bit default).
module tb_synchronous_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       w_enable;
   logic       read_enable;
   logic [9:0] wr_data;
   logic [9:0] r_data;
   logic       full;
   logic       empty;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [9:0]  model_q [$];
   logic [9:0]  exp_w;

   always #5 clk = ~clk;

   synchronous_fifo #(
      .DATA_WIDTH (10),
      .DEPTH      (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .w_enable    (w_enable),
      .read_enable (read_enable),
      .wr_data     (wr_data),
      .r_data      (r_data),
      .full        (full),
      .empty       (empty)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset       = 1'b0;
      w_enable    = 1'b0;
      read_enable = 1'b0;
      wr_data     = '0;

      // Reset held for 10 cycles, then released with no requests
      repeat (10) tick();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_rdata", 32'(r_data), 32'd0);
      reset = 1'b1;
      repeat (3) tick();
      check("idle_empty", 32'(empty), 32'd1);
      check("idle_full", 32'(full), 32'd0);

      // Fill with 0x001..0x010
      w_enable = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         wr_data = 10'(i);
         tick();
         if (i == 1) check("fill_empty_drop", 32'(empty), 32'd0);
         if (i < 16) check("fill_full_low", 32'(full), 32'd0);
         else        check("fill_full_high", 32'(full), 32'd1);
      end
      wr_data = 10'h3FF;
      tick();
      check("overflow_full", 32'(full), 32'd1);
      w_enable = 1'b0;

      // Drain; the dropped 0x3FF must never appear
      read_enable = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         check("drain_data", 32'(r_data), 32'(i));
         if (i == 1) check("drain_full_drop", 32'(full), 32'd0);
      end
      check("drain_empty", 32'(empty), 32'd1);
      tick();
      check("underflow_hold", 32'(r_data), 32'h010);
      check("underflow_empty", 32'(empty), 32'd1);
      read_enable = 1'b0;

      // Alternating writes with random data against a queue model
      for (int c = 0; c < 30; c++) begin
         w_enable = (c % 2 == 0);
         wr_data  = 10'($urandom_range(0, 1023));
         exp_w    = wr_data;
         tick();
         if (w_enable && model_q.size() < 16) model_q.push_back(exp_w);
         check("alt_empty", 32'(empty), 32'(model_q.size() == 0));
         check("alt_full", 32'(full), 32'(model_q.size() == 16));
      end
      w_enable    = 1'b0;
      read_enable = 1'b1;
      while (model_q.size() > 0) begin
         tick();
         exp_w = model_q.pop_front();
         check("alt_readback", 32'(r_data), 32'(exp_w));
      end
      check("alt_final_empty", 32'(empty), 32'd1);
      read_enable = 1'b0;

      // Half occupancy: simultaneous write+read keeps count, returns oldest
      w_enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_data = 10'(32'h100 + i);
         tick();
      end
      read_enable = 1'b1;
      wr_data     = 10'h1AA;
      tick();
      check("half_rw_data", 32'(r_data), 32'h100);
      check("half_rw_empty", 32'(empty), 32'd0);
      check("half_rw_full", 32'(full), 32'd0);
      read_enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr_data = 10'(32'h200 + i);
         tick();
      end
      check("refill_full", 32'(full), 32'd1);

      // Full: both requested, only the read is accepted
      read_enable = 1'b1;
      wr_data     = 10'h2FF;
      tick();
      check("full_rw_data", 32'(r_data), 32'h101);
      check("full_rw_full", 32'(full), 32'd0);
      w_enable = 1'b0;
      for (int i = 2; i < 8; i++) begin
         tick();
         check("full_rw_drain_a", 32'(r_data), 32'(32'h100 + i));
      end
      tick();
      check("full_rw_drain_b", 32'(r_data), 32'h1AA);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("full_rw_drain_c", 32'(r_data), 32'(32'h200 + i));
      end
      check("full_rw_empty", 32'(empty), 32'd1);

      // Empty: both requested, only the write is accepted, no bypass
      w_enable = 1'b1;
      wr_data  = 10'h155;
      tick();
      check("empty_rw_hold", 32'(r_data), 32'h207);
      check("empty_rw_empty", 32'(empty), 32'd0);
      w_enable = 1'b0;
      tick();
      check("empty_rw_data", 32'(r_data), 32'h155);
      check("empty_rw_empty2", 32'(empty), 32'd1);
      read_enable = 1'b0;

      // Stream 40 words at occupancy 1 across pointer wrap
      w_enable = 1'b1;
      for (int k = 0; k < 40; k++) begin
         wr_data     = 10'(32'h300 + k);
         read_enable = (k != 0);
         tick();
         if (k != 0) check("wrap_data", 32'(r_data), 32'(32'h300 + k - 1));
         check("wrap_empty", 32'(empty), 32'd0);
      end

      // Mid-stream asynchronous reset, checked before any clock edge
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_empty", 32'(empty), 32'd1);
      check("async_rst_full", 32'(full), 32'd0);
      check("async_rst_rdata", 32'(r_data), 32'd0);
      w_enable    = 1'b0;
      read_enable = 1'b0;
      tick();
      reset = 1'b1;
      repeat (2) tick();
      check("post_rst_empty", 32'(empty), 32'd1);
      check("post_rst_rdata", 32'(r_data), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/synchronous_fifo.md
# synchronous_fifo

Single-clock first-in/first-out buffer for 10-bit data words, 16 entries deep by default. It decouples a producer and a consumer that share one clock domain. Writes are accepted while the buffer is not full, and reads are accepted while it is not empty. Status flags `full` and `empty` let both sides throttle themselves.

## Interface
Parameters:
- `DATA_WIDTH`, default 10: width of each stored word.
- `DEPTH`, default 16: number of entries. Must be a power of two, 2 or more.
- `ADDR_WIDTH`, default $clog2(DEPTH): storage address width.

Ports:
- `clk`, input, 1 bit: the single clock. All state updates on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset. 0 resets immediately; release is synchronous to `clk`.
- `w_enable`, input, 1 bit: write request for the current cycle.
- `read_enable`, input, 1 bit: read request for the current cycle.
- `wr_data`, input, DATA_WIDTH bits: word to store when a write is accepted.
- `r_data`, output, DATA_WIDTH bits: registered read data.
- `full`, output, 1 bit: 1 when DEPTH words are stored.
- `empty`, output, 1 bit: 1 when 0 words are stored.

## Operation
- Write pointer and read pointer are each ADDR_WIDTH+1 bits. The MSB is a wrap bit.
- `empty` = (wptr == rptr).
- `full` = (the low ADDR_WIDTH bits are equal) and (the wrap bits differ).
- Both flags are decoded combinationally from the registered pointers.
- Write accept condition: `w_enable` && !`full`.
  - `wr_data` is stored at mem[wptr[ADDR_WIDTH-1:0]].
  - wptr increments by 1, modulo 2^(ADDR_WIDTH+1).
- Read accept condition: `read_enable` && !`empty`.
  - `r_data` is loaded from mem[rptr[ADDR_WIDTH-1:0]].
  - rptr increments by 1.
- Rejected requests have no effect:
  - A write while full is dropped. Memory and wptr are unchanged, and no error is signalled.
  - A read while empty leaves `r_data` holding its last value. rptr is unchanged.
- Simultaneous write and read in the same cycle:
  - Each is evaluated independently against the flags sampled at that edge.
  - When neither full nor empty, both are accepted and occupancy is unchanged.
  - When full, only the read is accepted.
  - When empty, only the write is accepted. The word is not bypassed to `r_data`.
- Wrap-around: pointers roll over naturally, and data order is preserved across any number of wraps.
- Reset (`reset` = 0, at any time including mid-operation):
  - wptr = 0, rptr = 0, `r_data` = 0.
  - `empty` = 1, `full` = 0.
  - Memory contents are not cleared. They are unreachable until rewritten.

## Timing
- Write-to-flag latency is 1 cycle. `empty` deasserts after the edge that accepts the first write.
- Read latency is 1 cycle. `r_data` is valid after the edge at which the read is accepted.
- `full` asserts after the edge that accepts the DEPTH-th outstanding write.
- `full` deasserts after the edge that accepts a read from a full FIFO.
- No combinational path from `w_enable` or `read_enable` to `full`/`empty` within a cycle.
- Throughput is one write and one read per cycle.

## Structure
- Shared package `fifo_pkg`:
  - Default constants DATA_WIDTH = 10 and DEPTH = 16.
  - A function returning the pointer width.
- Sub-module `fifo_mem`: a DEPTH x DATA_WIDTH register array.
  - One synchronous write port.
  - One registered read port.
  - Instantiated once.
- Top level holds the pointer registers, accept logic and flag decode.

## Test plan
- Reset: hold `reset` = 0 for 10 cycles. Require `empty` = 1, `full` = 0, `r_data` = 0. Release it and require the FIFO to stay empty with no requests.
- Fill: write 16 words 0x001 through 0x010 on consecutive cycles.
  - `empty` drops after the first edge.
  - `full` rises after the 16th edge.
  - A 17th write of 0x3FF is dropped.
- Drain: read 16 times. Require `r_data` = 0x001 through 0x010 in order, each one cycle after its read edge. Require `empty` = 1 after the last read. A 17th read keeps `r_data` at 0x010.
- Alternating stimulus: toggle `w_enable` every cycle for 30 cycles with random data. Require occupancy and `full`/`empty` to match a reference queue model, then read everything back in order.
- Simultaneous access:
  - At half occupancy, a write plus read leaves the count unchanged and returns the oldest word.
  - When full, both requested accepts only the read.
  - When empty, both requested accepts only the write.
- Wrap and mid-run reset: stream 40 words through with occupancy held at or below 4. Require data order to be preserved across pointer wrap. Then assert `reset` mid-stream and require `empty` = 1 and `r_data` = 0 immediately, without waiting for a clock edge.
